// File: rtl/pop_rank_sorter.sv
// Ranking sorter: latches N distances and emits their indices ordered by
// distance, one selection per clock, ascending or descending per run.
module pop_rank_sorter #(
  parameter int unsigned N  = 50,
  parameter int unsigned W  = 12,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            desc,
  input  logic [IW:0]     count,
  input  logic [N*W-1:0]  in,
  output logic [N*IW-1:0] sorted,
  output logic [IW-1:0]   best_index,
  output logic            busy,
  output logic            done,
  output logic [1:0]      state_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              load, step;
  logic [W-1:0]      dist_q [N];
  logic              desc_q;
  logic [IW:0]       count_q, counter_q, count_clamped;
  logic [N-1:0]      used_q, sel_oh;
  logic [IW-1:0]     sel;
  logic [W-1:0]      best;
  logic              found;
  logic              last;
  logic [N*IW-1:0]   sorted_q;
  logic              busy_q, done_q;

  // Clamp requested population size to the number of slots
  always_comb begin
    count_clamped = (count > (IW+1)'(N)) ? (IW+1)'(N) : count;
  end

  // Final selection of a run is being written this cycle
  always_comb begin
    last = (counter_q == (count_q - (IW+1)'(1)));
  end

  // Next-state and control decode
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          load    = 1'b1;
          state_d = (count_clamped == '0) ? DONE : SORT;
        end
      end
      SORT: begin
        step = 1'b1;
        if (last) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pick the best unused live slot; strict compare keeps the lowest index on ties
  always_comb begin
    found = 1'b0;
    best  = '0;
    sel   = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (!used_q[i] && ((IW+1)'(i) < count_q)) begin
        if (!found || (desc_q ? (dist_q[i] > best) : (dist_q[i] < best))) begin
          found = 1'b1;
          best  = dist_q[i];
          sel   = IW'(i);
        end
      end
    end
  end

  // One-hot form of the selection for the used-mask update
  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < int'(N); i++) begin
      sel_oh[i] = found && (sel == IW'(i));
    end
  end

  // State register and registered status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == SORT);
      done_q  <= (state_d == DONE);
    end
  end

  // Operand latch, used mask, rank counter and result vector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N); i++) dist_q[i] <= '0;
      desc_q    <= 1'b0;
      count_q   <= '0;
      counter_q <= '0;
      used_q    <= '0;
      sorted_q  <= '0;
    end else if (load) begin
      for (int i = 0; i < int'(N); i++) dist_q[i] <= in[W*i +: W];
      desc_q    <= desc;
      count_q   <= count_clamped;
      counter_q <= '0;
      used_q    <= '0;
      sorted_q  <= '0;
    end else if (step) begin
      for (int r = 0; r < int'(N); r++) begin
        if (counter_q == (IW+1)'(r)) sorted_q[IW*r +: IW] <= sel;
      end
      used_q    <= used_q | sel_oh;
      counter_q <= counter_q + (IW+1)'(1);
    end
  end

  assign sorted     = sorted_q;
  assign best_index = sorted_q[IW-1:0];
  assign busy       = busy_q;
  assign done       = done_q;
  assign state_out  = state_q;

endmodule

// File: tb/tb_pop_rank_sorter.sv
// Directed bench for pop_rank_sorter with hand-derived rank tables.
module tb_pop_rank_sorter;

  localparam int unsigned N  = 50;
  localparam int unsigned W  = 12;
  localparam int unsigned IW = 6;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic            desc;
  logic [IW:0]     count;
  logic [N*W-1:0]  din;
  logic [N*IW-1:0] sorted;
  logic [IW-1:0]   best_index;
  logic            busy;
  logic            done;
  logic [1:0]      state_out;

  int n_vec = 0;
  int n_err = 0;
  int exp_rank [N];
  int edges, bcnt;

  pop_rank_sorter #(.N(N), .W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .desc       (desc),
    .count      (count),
    .in         (din),
    .sorted     (sorted),
    .best_index (best_index),
    .busy       (busy),
    .done       (done),
    .state_out  (state_out)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expectation
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_ranks(input string tag);
    for (int r = 0; r < int'(N); r++)
      chk($sformatf("%s_rank%0d", tag, r), 64'(sorted[IW*r +: IW]), 64'(exp_rank[r]));
  endtask

  task automatic load_down;
    for (int i = 0; i < int'(N); i++) din[W*i +: W] = W'(49 - i);
  endtask

  // Start a run and wait (bounded) for done; optionally disturb inputs mid-sort
  task automatic run(input logic d, input int cnt, input int poke,
                     output int e, output int b);
    desc  = d;
    count = 7'(cnt);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    e = 1;
    b = 0;
    chk("done_after_start", 64'(done), 64'(cnt == 0));
    while (!done && e < 200) begin
      b += int'(busy);
      if (e == poke) begin
        start = 1'b1;
        desc  = ~desc;
        count = 7'd3;
        for (int i = 0; i < int'(N); i++) din[W*i +: W] = W'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      e++;
    end
    start = 1'b0;
    if (!done) chk("timeout", 64'(done), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    desc  = 1'b0;
    count = '0;
    din   = '0;
    #12;
    chk("rst_state", 64'(state_out), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_sorted_zero", 64'(sorted == '0), 64'd1);
    chk("rst_best", 64'(best_index), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Ascending on a descending ramp
    load_down();
    run(1'b0, 50, -1, edges, bcnt);
    chk("asc_latency", 64'(edges), 64'd51);
    chk("asc_busy_cycles", 64'(bcnt), 64'd50);
    for (int r = 0; r < int'(N); r++) exp_rank[r] = 49 - r;
    check_ranks("asc");
    chk("asc_best", 64'(best_index), 64'd49);
    chk("asc_state", 64'(state_out), 64'd2);
    repeat (3) @(posedge clk);
    #1;
    chk("asc_hold_done", 64'(done), 64'd1);
    chk("asc_hold_best", 64'(best_index), 64'd49);

    // Descending on the same input
    run(1'b1, 50, -1, edges, bcnt);
    chk("desc_latency", 64'(edges), 64'd51);
    for (int r = 0; r < int'(N); r++) exp_rank[r] = r;
    check_ranks("desc");
    chk("desc_best", 64'(best_index), 64'd0);

    // All maximum values: stable order, each index once
    for (int i = 0; i < int'(N); i++) din[W*i +: W] = 12'hFFF;
    run(1'b0, 50, -1, edges, bcnt);
    for (int r = 0; r < int'(N); r++) exp_rank[r] = r;
    check_ranks("max");
    begin
      logic [N-1:0] seen;
      seen = '0;
      for (int r = 0; r < int'(N); r++) seen[sorted[IW*r +: IW]] = 1'b1;
      chk("max_perm", 64'(&seen), 64'd1);
    end

    // Partial population of 5
    din = '0;
    din[W*0 +: W] = 12'd7;
    din[W*1 +: W] = 12'd3;
    din[W*2 +: W] = 12'd3;
    din[W*3 +: W] = 12'd9;
    din[W*4 +: W] = 12'd1;
    run(1'b0, 5, -1, edges, bcnt);
    chk("part_latency", 64'(edges), 64'd6);
    for (int r = 0; r < int'(N); r++) exp_rank[r] = 0;
    exp_rank[0] = 4; exp_rank[1] = 1; exp_rank[2] = 2; exp_rank[3] = 0; exp_rank[4] = 3;
    check_ranks("part");

    // Empty population
    run(1'b0, 0, -1, edges, bcnt);
    chk("zero_latency", 64'(edges), 64'd1);
    chk("zero_sorted", 64'(sorted == '0), 64'd1);
    chk("zero_busy", 64'(bcnt), 64'd0);

    // Oversized count clamps to N
    load_down();
    run(1'b0, 60, -1, edges, bcnt);
    chk("clamp_latency", 64'(edges), 64'd51);
    for (int r = 0; r < int'(N); r++) exp_rank[r] = 49 - r;
    check_ranks("clamp");

    // Start and new data during SORT are ignored
    load_down();
    run(1'b0, 50, 10, edges, bcnt);
    chk("poke_latency", 64'(edges), 64'd51);
    check_ranks("poke");

    // Reset in the middle of a sort
    load_down();
    desc  = 1'b0;
    count = 7'd50;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_state", 64'(state_out), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_sorted_zero", 64'(sorted == '0), 64'd1);
    chk("midrst_best", 64'(best_index), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fresh sort after reset: slots 25..49 hold the smaller values
    for (int i = 0; i < int'(N); i++)
      din[W*i +: W] = (i < 25) ? W'(100 + i) : W'(50 + i - 25);
    run(1'b0, 50, -1, edges, bcnt);
    chk("post_latency", 64'(edges), 64'd51);
    for (int r = 0; r < int'(N); r++) exp_rank[r] = (r < 25) ? 25 + r : r - 25;
    check_ranks("post");
    chk("post_best", 64'(best_index), 64'd25);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pop_rank_sorter.md
Name: pop_rank_sorter

Overview:
- Parametrised ranking sorter for the GA population stage.
- Latches N fitness distances of width W on `start`.
- Emits the population indices ordered by distance, one selection per clock: ascending (best-first, smallest distance) or descending, selected per run.
- Supports a partial population (`count` live entries). Uses a used-mask so that maximum-valued distances rank correctly. Sits between the fitness evaluator and the selection/crossover stage.

Parameters:
- N, 50, population size (number of distance slots), 2..64.
- W, 12, distance width in bits.
- IW, derived localparam = clog2(N), index width (6 at N=50); not overridable.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a sort; sampled only in IDLE or DONE.
- desc  in  1  order mode, latched with start: 0 = ascending, 1 = descending.
- count  in  IW+1  live entries, latched with start; values above N clamp to N.
- in  in  N*W  packed distances; slot i = in[W*i +: W]; latched with start.
- sorted  out  N*IW  packed result; rank r = sorted[IW*r +: IW].
- best_index  out  IW  equals rank 0 of sorted; valid when done.
- busy  out  1  high in SORT.
- done  out  1  high in DONE.
- state_out  out  2  debug: current state encoding.

Behaviour:
- Reset (async, rst_n low): state = IDLE, sorted = 0, best_index = 0, busy = 0, done = 0, counter = 0, used mask = 0, latched distances = 0.
- State encoding: IDLE = 0, SORT = 1, DONE = 2; 3 is illegal and returns to IDLE on the next edge.
- IDLE → SORT when start = 1. On the same edge:
  - latch in, desc and clamped count;
  - clear the used mask;
  - set counter = 0;
  - clear sorted to all zeros.
- IDLE with count = 0 at start: go straight to DONE with sorted = 0.
- SORT selection, each cycle, combinational over unused slots i < count_l:
  - ascending: pick the minimum distance;
  - descending: pick the maximum distance;
  - tie: lowest index wins (stable);
  - slots ≥ count_l are never selected.
- SORT update on each edge:
  - write the selected index to rank `counter`;
  - set used[sel] = 1;
  - counter += 1.
- SORT → DONE on the edge where counter == count_l − 1 (last selection written).
- Latency: start edge to done high = count_l + 1 rising edges; a full N = 50 run takes 51 edges.
- Ranks ≥ count_l stay 0.
- DONE: done = 1 and sorted is held stable until the next start.
  - start in DONE behaves as from IDLE: new latch, done drops on that edge.
  - DONE never returns to IDLE on its own.
- start while busy (SORT) is ignored; inputs changing during SORT have no effect.
- Distances equal to 2^W − 1 are sorted normally; no sentinel values are used.
- rst_n asserted mid-SORT: immediate return to reset values; the partial result is discarded.
- Comparator loop must be synthesizable.
- Distances are unsigned, W bits.

Test Plan:
- Ascending, N = 50, count = 50, distance[i] = 49 − i, start pulse → done after 51 edges; sorted rank r = 49 − r; best_index = 49; busy high exactly 50 cycles.
- Descending, same input → sorted rank r = r; best_index = 0.
- Ties and max values: all distances = 12'hFFF, count = 50 → sorted rank r = r (stable lowest-index-first); every index appears exactly once.
- Partial population: count = 5, distances slots 0..4 = {7, 3, 3, 9, 1}, other slots = 0 → ranks 0..4 = {4, 1, 2, 0, 3}; ranks 5..49 = 0; done after 6 edges.
- count = 0 → done one edge after start, sorted = 0.
- count = 60 → clamps to 50.
- Robustness:
  - start and changed in during SORT → result unaffected;
  - rst_n pulsed low at rank 20 → all outputs 0 immediately, state IDLE;
  - a new start then sorts correctly;
  - start in DONE with new data → done falls, new result after count + 1 edges.
